// File: rtl/d_fifo_arbiter.sv
// Round-robin pop arbiter for the D0/D1 FIFOs feeding one registered output stream.
// Pops are combinational; FIFO data arrives one cycle later and is registered the cycle after.
module d_fifo_arbiter #(
  parameter int data_width = 6,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  input  logic [data_width-1:0] data_in_D0,
  input  logic [data_width-1:0] data_in_D1,
  input  logic                  pause_in,
  output logic                  pop_D0,
  output logic                  pop_D1,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out,
  output logic                  idle_out,
  output logic [cnt_width-1:0]  words_D0,
  output logic [cnt_width-1:0]  words_D1
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0] state;
  logic       run;
  logic       pop;
  logic       inflight;
  logic       last_grant;
  logic       src_q;

  assign run      = reset_L & init;
  assign inflight = (state == ACTIVE);
  assign pop      = pop_D0 | pop_D1;
  assign idle_out = empty_D0 & empty_D1 & ~inflight & ~valid_out;

  // last_grant==1 means D1 was served last, so D0 wins a tie.
  always_comb begin
    pop_D0 = 1'b0;
    pop_D1 = 1'b0;
    if (run && !pause_in) begin
      if (!empty_D0 && !empty_D1) begin
        pop_D0 = last_grant;
        pop_D1 = ~last_grant;
      end else begin
        pop_D0 = ~empty_D0;
        pop_D1 = ~empty_D1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      src_q      <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      src_out    <= 1'b0;
      words_D0   <= '0;
      words_D1   <= '0;
    end else begin
      state <= pop ? ACTIVE : IDLE;
      if (pop) begin
        last_grant <= pop_D1;
        src_q      <= pop_D1;
      end
      // The FIFO drives the popped word this cycle; register it with its source.
      if (inflight) begin
        data_out  <= src_q ? data_in_D1 : data_in_D0;
        src_out   <= src_q;
        valid_out <= 1'b1;
        if (src_q) words_D1 <= words_D1 + 1'b1;
        else       words_D0 <= words_D0 + 1'b1;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_d_fifo_arbiter.sv
// Directed bench for d_fifo_arbiter with queue-based FIFO models on both inputs.
module tb_d_fifo_arbiter;

  logic       clk = 1'b0;
  logic       reset_L, init, pause_in;
  logic       empty_D0 = 1'b1, empty_D1 = 1'b1;
  logic [5:0] data_in_D0 = '0, data_in_D1 = '0;
  logic       pop_D0, pop_D1, valid_out, src_out, idle_out;
  logic [5:0] data_out;
  logic [7:0] words_D0, words_D1;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int n_chk = 0;
  int n_err = 0;

  d_fifo_arbiter #(.data_width(6), .cnt_width(8)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .empty_D0(empty_D0), .empty_D1(empty_D1),
    .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
    .pause_in(pause_in), .pop_D0(pop_D0), .pop_D1(pop_D1),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .idle_out(idle_out), .words_D0(words_D0), .words_D1(words_D1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO models: read data valid the cycle after a pop, empty updates at the pop edge.
  always @(posedge clk) begin
    chk("pop_both", {31'b0, pop_D0 & pop_D1}, 32'd0);
    if (pop_D0) begin
      chk("pop_empty_D0", {31'b0, q0.size() == 0}, 32'd0);
      if (q0.size() > 0) data_in_D0 <= q0.pop_front();
    end
    if (pop_D1) begin
      chk("pop_empty_D1", {31'b0, q1.size() == 0}, 32'd0);
      if (q1.size() > 0) data_in_D1 <= q1.pop_front();
    end
    empty_D0 <= (q0.size() == 0);
    empty_D1 <= (q1.size() == 0);
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic pops(input string tag, input logic e0, input logic e1);
    chk({tag, "_pop_D0"}, {31'b0, pop_D0}, {31'b0, e0});
    chk({tag, "_pop_D1"}, {31'b0, pop_D1}, {31'b0, e1});
  endtask

  task automatic outw(input string tag, input logic v, input logic [5:0] d, input logic s);
    chk({tag, "_valid"}, {31'b0, valid_out}, {31'b0, v});
    chk({tag, "_data"}, {26'b0, data_out}, {26'b0, d});
    if (v) chk({tag, "_src"}, {31'b0, src_out}, {31'b0, s});
  endtask

  // Hold init low for one edge while refilling the FIFOs, then run.
  task automatic clear_and_load(input int n0, input logic [5:0] b0, input int n1, input logic [5:0] b1);
    init = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < n0; i++) q0.push_back(b0 + 6'(i));
    for (int i = 0; i < n1; i++) q1.push_back(b1 + 6'(i));
    nxt();
    init = 1'b1;
    #1;
  endtask

  initial begin
    reset_L = 1'b0; init = 1'b1; pause_in = 1'b0;
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h21); q1.push_back(6'h22);

    // reset held with both FIFOs non-empty
    repeat (3) begin
      nxt();
      pops("rst", 1'b0, 1'b0);
      outw("rst", 1'b0, 6'h00, 1'b0);
      chk("rst_words_D0", {24'b0, words_D0}, 32'd0);
      chk("rst_words_D1", {24'b0, words_D1}, 32'd0);
    end
    reset_L = 1'b1; #1;
    pops("alt0", 1'b1, 1'b0);

    // alternation
    nxt(); pops("alt1", 1'b0, 1'b1); outw("alt1", 1'b0, 6'h00, 1'b0);
    nxt(); pops("alt2", 1'b1, 1'b0); outw("alt2", 1'b1, 6'h01, 1'b0);
    nxt(); pops("alt3", 1'b0, 1'b1); outw("alt3", 1'b1, 6'h21, 1'b1);
    nxt(); pops("alt4", 1'b0, 1'b0); outw("alt4", 1'b1, 6'h02, 1'b0);
    chk("alt4_idle", {31'b0, idle_out}, 32'd0);
    nxt(); outw("alt5", 1'b1, 6'h22, 1'b1);
    nxt(); outw("alt6", 1'b0, 6'h00, 1'b0);
    chk("alt_words_D0", {24'b0, words_D0}, 32'd2);
    chk("alt_words_D1", {24'b0, words_D1}, 32'd2);
    chk("alt_idle", {31'b0, idle_out}, 32'd1);

    // single source D1
    clear_and_load(0, 6'h00, 3, 6'h31);
    pops("one0", 1'b0, 1'b1);
    nxt(); pops("one1", 1'b0, 1'b1); outw("one1", 1'b0, 6'h00, 1'b0);
    nxt(); pops("one2", 1'b0, 1'b1); outw("one2", 1'b1, 6'h31, 1'b1);
    nxt(); pops("one3", 1'b0, 1'b0); outw("one3", 1'b1, 6'h32, 1'b1);
    nxt(); outw("one4", 1'b1, 6'h33, 1'b1);
    nxt(); outw("one5", 1'b0, 6'h00, 1'b0);
    chk("one_words_D1", {24'b0, words_D1}, 32'd3);
    chk("one_words_D0", {24'b0, words_D0}, 32'd0);

    // pause right after a D0 pop
    clear_and_load(2, 6'h11, 2, 6'h31);
    pops("pse0", 1'b1, 1'b0);
    nxt(); pause_in = 1'b1; #1;
    pops("pse1", 1'b0, 1'b0); outw("pse1", 1'b0, 6'h00, 1'b0);
    nxt(); outw("pse2", 1'b1, 6'h11, 1'b0);
    pause_in = 1'b0; #1;
    pops("pse2", 1'b0, 1'b1);
    nxt(); pops("pse3", 1'b1, 1'b0); outw("pse3", 1'b0, 6'h00, 1'b0);
    nxt(); pops("pse4", 1'b0, 1'b1); outw("pse4", 1'b1, 6'h31, 1'b1);
    nxt(); pops("pse5", 1'b0, 1'b0); outw("pse5", 1'b1, 6'h12, 1'b0);
    nxt(); outw("pse6", 1'b1, 6'h32, 1'b1);
    nxt(); outw("pse7", 1'b0, 6'h00, 1'b0);
    chk("pse_words_D0", {24'b0, words_D0}, 32'd2);
    chk("pse_words_D1", {24'b0, words_D1}, 32'd2);

    // init drop with a D0 read in flight and D1 next in line
    clear_and_load(3, 6'h01, 1, 6'h3a);
    pops("ini0", 1'b1, 1'b0);
    nxt(); pops("ini1", 1'b0, 1'b1);
    init = 1'b0; #1;
    pops("ini1_held", 1'b0, 1'b0);
    nxt(); outw("ini2", 1'b0, 6'h00, 1'b0);
    chk("ini2_words_D0", {24'b0, words_D0}, 32'd0);
    chk("ini2_words_D1", {24'b0, words_D1}, 32'd0);
    init = 1'b1; #1;
    pops("ini2", 1'b1, 1'b0);

    // counter wrap: 256 words from D0
    clear_and_load(256, 6'h00, 0, 6'h00);
    repeat (256) nxt();
    chk("wrap_words_D0_255", {24'b0, words_D0}, 32'd255);
    nxt();
    chk("wrap_words_D0_0", {24'b0, words_D0}, 32'd0);
    chk("wrap_words_D1", {24'b0, words_D1}, 32'd0);
    outw("wrap_last", 1'b1, 6'h3f, 1'b0);
    nxt();
    chk("wrap_idle", {31'b0, idle_out}, 32'd1);
    outw("wrap_end", 1'b0, 6'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
